// File: rtl/debug_pkg.sv
// Shared types for the debug readout controller: sweep state encoding and
// the bank-select width helper used to size bank_sel.
package debug_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } state_e;

    // A single bank still needs a 1-bit select port.
    function automatic int bank_w(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

endpackage

// File: rtl/debug_rdout_fifo.sv
// Small synchronous FIFO that absorbs the memory read latency of a debug sweep.
// Exposes its occupancy so the issuer can reserve space before reading.
module debug_rdout_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_q];
    assign count   = count_q;

    // NOTE: storage is deliberately not reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem_q[wr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= ptr_inc(wr_q);
            if (do_pop)  rd_q <= ptr_inc(rd_q);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // The issuer's credit check must make a push into a full FIFO impossible.
    push_when_full_a: assert property (@(posedge clk) disable iff (!rstn || clr) !(push && full));

endmodule

// File: rtl/debug_readout_ctrl.sv
// Debug dump sequencer: sweeps one bank's addresses, absorbs read latency in a credited FIFO
// and streams words out with last marking. DEBUG_RDOUT_CKSUM_EN adds an XOR checksum port.
module debug_readout_ctrl
    import debug_pkg::*;
#(
    parameter int LENGTH     = 12000,
    parameter int ADDR_W     = $clog2(LENGTH),
    parameter int DATA_W     = 32,
    parameter int NUM_BANKS  = 4,
    parameter int BANK_W     = bank_w(NUM_BANKS),
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = RD_LAT + 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [BANK_W-1:0]    bank_sel,
    output logic [NUM_BANKS-1:0] mem_cs,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic [DATA_W-1:0]    m_data,
    output logic                 m_valid,
    output logic                 m_last,
    input  logic                 m_ready,
    output logic                 busy,
    output logic                 done
`ifdef DEBUG_RDOUT_CKSUM_EN
    ,
    output logic [DATA_W-1:0]    cksum
`endif
);

    localparam int                CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int                FL_W      = $clog2(RD_LAT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LENGTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [NUM_BANKS-1:0]  cs_q, cs_d;
    logic [CNT_W-1:0]      inflight_q, inflight_d;
    logic [FL_W-1:0]       flush_q, flush_d;
    logic [RD_LAT-1:0]     ret_vld_q;
    logic [RD_LAT-1:0]     ret_last_q;

    logic                  start_ok;
    logic                  abort_ok;
    logic                  issue;
    logic                  ret;
    logic                  push;
    logic                  pop;
    logic                  fifo_clr;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [DATA_W:0]       fifo_rdata;

    assign start_ok = start && !abort && (32'(bank_sel) < NUM_BANKS);
    assign abort_ok = abort && (state_q == SWEEP || state_q == DRAIN);

    // Credit check: FIFO slots already holding data plus reads still in the memory pipe.
    assign issue = (state_q == SWEEP) && !abort &&
                   (({1'b0, fifo_count} + {1'b0, inflight_q}) < (CNT_W + 1)'(FIFO_DEPTH));

    assign ret      = ret_vld_q[RD_LAT-1];
    assign push     = ret && (state_q == SWEEP || state_q == DRAIN);
    assign fifo_clr = abort_ok || (state_q == FLUSH);

    assign m_valid   = !fifo_empty;
    assign m_data    = fifo_rdata[DATA_W-1:0];
    assign m_last    = m_valid && fifo_rdata[DATA_W];
    assign pop       = m_valid && m_ready;
    assign done      = (state_q == DRAIN) && pop && m_last && !abort;
    assign busy      = (state_q != IDLE);
    assign mem_rd_en = issue;
    assign mem_addr  = addr_q;
    assign mem_cs    = cs_q;

    assign inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(ret);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cs_d    = cs_q;
        flush_d = flush_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = SWEEP;
                    addr_d  = '0;
                    cs_d    = NUM_BANKS'(1) << bank_sel;
                end
            end
            SWEEP: begin
                if (abort) begin
                    state_d = FLUSH;
                    flush_d = '0;
                end else if (issue) begin
                    if (addr_q == LAST_ADDR) state_d = DRAIN;
                    else                     addr_d  = addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = FLUSH;
                    flush_d = '0;
                end else if (done) begin
                    state_d = IDLE;
                    addr_d  = '0;
                    cs_d    = '0;
                end
            end
            FLUSH: begin
                // Every read outstanding at abort has returned and been dropped after RD_LAT cycles.
                if (flush_q == FL_W'(RD_LAT - 1)) begin
                    state_d = IDLE;
                    addr_d  = '0;
                    cs_d    = '0;
                end else begin
                    flush_d = flush_q + FL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cs_q       <= '0;
            inflight_q <= '0;
            flush_q    <= '0;
            ret_vld_q  <= '0;
            ret_last_q <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            cs_q          <= cs_d;
            inflight_q    <= inflight_d;
            flush_q       <= flush_d;
            ret_vld_q[0]  <= issue;
            ret_last_q[0] <= issue && (addr_q == LAST_ADDR);
            for (int i = 1; i < RD_LAT; i++) begin
                ret_vld_q[i]  <= ret_vld_q[i-1];
                ret_last_q[i] <= ret_last_q[i-1];
            end
        end
    end

    debug_rdout_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (fifo_clr),
        .push  (push),
        .wdata ({ret_last_q[RD_LAT-1], mem_rdata}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef DEBUG_RDOUT_CKSUM_EN
    logic [DATA_W-1:0] cksum_q;
    logic              cksum_acc;

    assign cksum_acc = pop && !abort_ok;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cksum_q <= '0;
        end else if ((state_q == IDLE) && start_ok) begin
            cksum_q <= '0;
        end else if (cksum_acc) begin
            cksum_q <= cksum_q ^ m_data;
        end
    end

    // Fold in the word accepted this cycle so the final value is visible in the done cycle.
    assign cksum = cksum_acc ? (cksum_q ^ m_data) : cksum_q;
`endif

endmodule

// File: tb/tb_debug_readout_ctrl.sv
// Directed bench for debug_readout_ctrl: 8-word sweeps over five banks with a RD_LAT=2 memory model.
// Five banks are used so that bank_sel=5 is an out-of-range encoding.
module tb_debug_readout_ctrl;

    localparam int LENGTH     = 8;
    localparam int ADDR_W     = 3;
    localparam int DATA_W     = 32;
    localparam int NUM_BANKS  = 5;
    localparam int BANK_W     = 3;
    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 4;

    logic                 clk;
    logic                 rstn;
    logic                 start;
    logic                 abort;
    logic [BANK_W-1:0]    bank_sel;
    logic [NUM_BANKS-1:0] mem_cs;
    logic                 mem_rd_en;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_rdata;
    logic [DATA_W-1:0]    m_data;
    logic                 m_valid;
    logic                 m_last;
    logic                 m_ready;
    logic                 busy;
    logic                 done;
`ifdef DEBUG_RDOUT_CKSUM_EN
    logic [DATA_W-1:0]    cksum;
`endif

    debug_readout_ctrl #(
        .LENGTH     (LENGTH),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .NUM_BANKS  (NUM_BANKS),
        .BANK_W     (BANK_W),
        .RD_LAT     (RD_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .abort     (abort),
        .bank_sel  (bank_sel),
        .mem_cs    (mem_cs),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .busy      (busy),
        .done      (done)
`ifdef DEBUG_RDOUT_CKSUM_EN
        ,
        .cksum     (cksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank 3 holds 1..8 (checksum 8'h08); other banks hold 0xB0bb00aa.
    function automatic logic [31:0] mem_word(input int b, input int a);
        if (b == 3) return 32'(a + 1);
        return 32'hB000_0000 | 32'(b << 16) | 32'(a);
    endfunction

    function automatic int cs_bank(input logic [NUM_BANKS-1:0] cs);
        int b = 0;
        for (int i = 0; i < NUM_BANKS; i++) if (cs[i]) b = i;
        return b;
    endfunction

    // Two-stage read pipe: data is valid RD_LAT cycles after the read strobe.
    logic [31:0] rd_p1;
    always @(posedge clk) begin
        rd_p1     <= mem_rd_en ? mem_word(cs_bank(mem_cs), int'(mem_addr)) : 32'hDEAD_BEEF;
        mem_rdata <= rd_p1;
    end

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int sb_bank, sb_idx, issued, accepted, start_cyc, first_valid_cyc, done_cyc;
    logic [31:0] sb_xor;
    bit sweeping = 0;
    bit done_seen = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already set; observe at negedge, then advance past posedge.
    task automatic cycle();
        logic acc;
        bit   exp_en;
        @(negedge clk);
        acc = m_valid && m_ready;
        if (m_valid) begin
            check("m_data", m_data, mem_word(sb_bank, sb_idx));
            check("m_last", m_last, sb_idx == LENGTH - 1);
        end
        check("done", done, acc && (sb_idx == LENGTH - 1) && !abort);
        if (sweeping) begin
            exp_en = !abort && (issued < LENGTH) && ((issued - accepted) < FIFO_DEPTH);
            check("rd_en", mem_rd_en, exp_en);
            if (mem_rd_en) check("mem_addr", mem_addr, issued);
        end else begin
            check("rd_en_quiet", mem_rd_en, 1'b0);
        end
        if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (done) begin
            done_seen = 1;
            done_cyc  = cyc;
`ifdef DEBUG_RDOUT_CKSUM_EN
            check("cksum_at_done", cksum, sb_xor ^ mem_word(sb_bank, sb_idx));
`endif
        end
        if (mem_rd_en) issued++;
        if (acc) begin
            sb_xor = sb_xor ^ mem_word(sb_bank, sb_idx);
            sb_idx++;
            accepted++;
        end
        if (done) sweeping = 0;
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic begin_sweep(input int b);
        sb_bank         = b;
        sb_idx          = 0;
        sb_xor          = '0;
        issued          = 0;
        accepted        = 0;
        first_valid_cyc = -1;
        done_seen       = 0;
        start_cyc       = cyc;
        bank_sel        = BANK_W'(b);
        start           = 1'b1;
        cycle();
        start           = 1'b0;
        sweeping        = 1;
    endtask

    task automatic run_to_done(input string tag, input int budget);
        int n = 0;
        while (!done_seen && n < budget) begin
            cycle();
            n++;
        end
        check({tag, "_done_seen"}, done_seen, 1'b1);
        check({tag, "_words"}, sb_idx, LENGTH);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_cs"}, mem_cs, '0);
        check({tag, "_rd_en"}, mem_rd_en, 1'b0);
        check({tag, "_addr"}, mem_addr, '0);
        check({tag, "_valid"}, m_valid, 1'b0);
        check({tag, "_last"}, m_last, 1'b0);
        check({tag, "_done"}, done, 1'b0);
    endtask

    initial begin
        rstn     = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        bank_sel = '0;
        m_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b1;
        check_idle("reset");
`ifdef DEBUG_RDOUT_CKSUM_EN
        check("reset_cksum", cksum, 32'h0);
`endif

        // Full-rate sweep of bank 2.
        m_ready = 1'b1;
        begin_sweep(2);
        check("t1_cs", mem_cs, 5'b00100);
        check("t1_busy", busy, 1'b1);
        run_to_done("t1", 40);
        check("t1_first_valid", first_valid_cyc - start_cyc, 4);
        check("t1_done_latency", done_cyc - start_cyc, 11);
        check_idle("t1_end");

        // Toggling then stalled consumer on bank 0, with an ignored start while busy.
        m_ready = 1'b1;
        begin_sweep(0);
        for (int i = 0; i < 6; i++) begin
            m_ready = (i % 2 == 0);
            cycle();
        end
        m_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            start    = (i == 10);
            bank_sel = 3'd1;
            cycle();
        end
        start = 1'b0;
        check("t2_outstanding", issued - accepted, 4);
        check("t2_cs_held", mem_cs, 5'b00001);
        check("t2_valid_stalled", m_valid, 1'b1);
        m_ready = 1'b1;
        run_to_done("t2", 60);
        check_idle("t2_end");

        // Out-of-range bank and start+abort in IDLE are both ignored.
        bank_sel = 3'd5;
        start    = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        check_idle("bad_bank");
        bank_sel = 3'd2;
        start    = 1'b1;
        abort    = 1'b1;
        cycle();
        start = 1'b0;
        abort = 1'b0;
        cycle();
        check_idle("start_abort");

        // Abort before address 3 is issued, with one word already buffered.
        m_ready = 1'b0;
        begin_sweep(4);
        for (int i = 0; i < 3; i++) cycle();
        check("t4_issued", issued, 3);
        abort = 1'b1;
        check("t4_valid_before_abort", m_valid, 1'b1);
        cycle();
        abort    = 1'b0;
        sweeping = 0;
        check("t4_flush1_valid", m_valid, 1'b0);
        check("t4_flush1_busy", busy, 1'b1);
        cycle();
        check("t4_flush2_busy", busy, 1'b1);
        cycle();
        check_idle("t4_after_flush");
        check("t4_no_done", done_seen, 1'b0);
        m_ready = 1'b1;
        begin_sweep(4);
        run_to_done("t4_restart", 40);

        // Reset pulse mid-sweep, then a clean sweep of bank 3.
        begin_sweep(1);
        for (int i = 0; i < 5; i++) cycle();
        rstn = 1'b0;
        cycle();
        rstn     = 1'b1;
        sweeping = 0;
        check_idle("t5_reset");
        begin_sweep(3);
        check("t5_cs", mem_cs, 5'b01000);
        run_to_done("t5", 40);
`ifdef DEBUG_RDOUT_CKSUM_EN
        check("t5_cksum_final", cksum, 32'h0000_0008);
`endif
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check_idle("t5_idle_abort");
`ifdef DEBUG_RDOUT_CKSUM_EN
        check("t5_cksum_held", cksum, 32'h0000_0008);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
